// File: rtl/bit_memory_arbiter_if.sv
// Bundle between the four requesters and the shared-cell arbiter.
// Valid/ready: req[i] is a one-cycle write offer; a write is taken when gnt[i]/mem_save pulse one cycle later.
interface bit_memory_arbiter_if #(
    parameter int WIDTH = 1
);
    logic [3:0]         req;
    logic [3:0]         lock;
    logic [4*WIDTH-1:0] wdata;
    logic [3:0]         gnt;
    logic               mem_save;
    logic [WIDTH-1:0]   mem_in;
    logic               busy;
    logic               lock_expired;
    logic               dbg_state;
    logic [1:0]         dbg_ptr;

    modport master (
        output req, lock, wdata,
        input  gnt, mem_save, mem_in, busy, lock_expired, dbg_state, dbg_ptr
    );

    modport slave (
        input  req, lock, wdata,
        output gnt, mem_save, mem_in, busy, lock_expired, dbg_state, dbg_ptr
    );
endinterface

// File: rtl/bit_memory_arbiter.sv
// Round-robin write arbiter for one shared storage cell, with a bounded lock
// that lets one requester keep the cell for up to LOCK_MAX cycles.
module bit_memory_arbiter #(
    parameter int UUID     = 0,
    parameter     NAME     = "",
    parameter int WIDTH    = 1,
    parameter int LOCK_MAX = 8
) (
    input logic                 clk,
    input logic                 rst,
    bit_memory_arbiter_if.slave bus
);
    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] HOLD_LIMIT = CW'(LOCK_MAX);

    if (LOCK_MAX < 1 || UUID < 0) begin : g_bad_params
        $error("bit_memory_arbiter %s: LOCK_MAX must be >= 1 and UUID >= 0", NAME);
    end

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       owner_q, owner_d;
    logic [CW-1:0]    hold_q, hold_d;
    logic [3:0]       gnt_q, gnt_d;
    logic             save_q, save_d;
    logic [WIDTH-1:0] mem_in_q, mem_in_d;
    logic             expired_q, expired_d;

    logic             found;
    logic [1:0]       pick;
    logic [1:0]       cand;

    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        cand  = ptr_q;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        hold_d    = hold_q;
        gnt_d     = 4'b0000;
        save_d    = 1'b0;
        mem_in_d  = mem_in_q;
        expired_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d    = 4'b0001 << pick;
                    save_d   = 1'b1;
                    mem_in_d = bus.wdata[int'(pick)*WIDTH +: WIDTH];
                    if (bus.lock[pick]) begin
                        state_d = LOCKED;
                        owner_d = pick;
                        hold_d  = CW'(1);
                    end else begin
                        ptr_d = pick + 2'd1;
                    end
                end
            end
            LOCKED: begin
                // Release (voluntary or forced) always costs one bubble cycle.
                if (!bus.lock[owner_q] || hold_q == HOLD_LIMIT) begin
                    state_d   = IDLE;
                    ptr_d     = owner_q + 2'd1;
                    hold_d    = '0;
                    expired_d = bus.lock[owner_q];
                end else begin
                    hold_d = hold_q + CW'(1);
                    if (bus.req[owner_q]) begin
                        gnt_d    = 4'b0001 << owner_q;
                        save_d   = 1'b1;
                        mem_in_d = bus.wdata[int'(owner_q)*WIDTH +: WIDTH];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            owner_q   <= 2'd0;
            hold_q    <= '0;
            gnt_q     <= 4'b0000;
            save_q    <= 1'b0;
            mem_in_q  <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            hold_q    <= hold_d;
            gnt_q     <= gnt_d;
            save_q    <= save_d;
            mem_in_q  <= mem_in_d;
            expired_q <= expired_d;
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.mem_save     = save_q;
    assign bus.mem_in       = mem_in_q;
    assign bus.busy         = (state_q == LOCKED);
    assign bus.lock_expired = expired_q;
    assign bus.dbg_state    = state_q;
    assign bus.dbg_ptr      = ptr_q;
endmodule

// File: tb/tb_bit_memory_arbiter.sv
// Directed bench for bit_memory_arbiter: two instances (LOCK_MAX 8 and 1) share stimulus
// and are checked every cycle against a cycle-count model plus literal pins.
module tb_bit_memory_arbiter;
    localparam int W = 4;
    localparam int LM_A = 8;
    localparam int LM_B = 1;

    logic         clk;
    logic         rst;
    logic [3:0]   req;
    logic [3:0]   lock;
    logic [4*W-1:0] wdata;

    int n_cmp = 0;
    int n_err = 0;

    bit_memory_arbiter_if #(.WIDTH(W)) bus_a ();
    bit_memory_arbiter_if #(.WIDTH(W)) bus_b ();

    assign bus_a.req = req;
    assign bus_a.lock = lock;
    assign bus_a.wdata = wdata;
    assign bus_b.req = req;
    assign bus_b.lock = lock;
    assign bus_b.wdata = wdata;

    bit_memory_arbiter #(.UUID(1), .NAME("arb_a"), .WIDTH(W), .LOCK_MAX(LM_A)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    bit_memory_arbiter #(.UUID(2), .NAME("arb_b"), .WIDTH(W), .LOCK_MAX(LM_B)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Model: lock tenure measured as edges since entry, grants from modular scan.
    int         edge_no = 0;
    bit         m_valid[2];
    bit         m_locked[2];
    int         m_ptr[2];
    int         m_owner[2];
    int         m_entry[2];
    logic [3:0] e_gnt[2];
    logic       e_save[2];
    logic [W-1:0] e_in[2];
    logic       e_busy[2];
    logic       e_exp[2];

    task automatic model_grant(input int n, input int i);
        e_gnt[n]  = 4'(1 << i);
        e_save[n] = 1'b1;
        e_in[n]   = wdata[i*W +: W];
    endtask

    task automatic model_step(input int n, input int lm);
        bit done;
        int i;
        e_gnt[n]  = 4'b0000;
        e_save[n] = 1'b0;
        e_exp[n]  = 1'b0;
        if (rst) begin
            m_valid[n]  = 1'b1;
            m_locked[n] = 1'b0;
            m_ptr[n]    = 0;
            e_in[n]     = '0;
        end else if (m_locked[n]) begin
            if (!lock[m_owner[n]]) begin
                m_locked[n] = 1'b0;
                m_ptr[n]    = (m_owner[n] + 1) % 4;
            end else if (edge_no - m_entry[n] == lm) begin
                m_locked[n] = 1'b0;
                m_ptr[n]    = (m_owner[n] + 1) % 4;
                e_exp[n]    = 1'b1;
            end else if (req[m_owner[n]]) begin
                model_grant(n, m_owner[n]);
            end
        end else begin
            done = 1'b0;
            for (int k = 0; k < 4; k++) begin
                i = (m_ptr[n] + k) % 4;
                if (!done && req[i]) begin
                    done = 1'b1;
                    model_grant(n, i);
                    if (lock[i]) begin
                        m_locked[n] = 1'b1;
                        m_owner[n]  = i;
                        m_entry[n]  = edge_no;
                    end else begin
                        m_ptr[n] = (i + 1) % 4;
                    end
                end
            end
        end
        e_busy[n] = m_locked[n];
    endtask

    always @(posedge clk) begin
        edge_no++;
        model_step(0, LM_A);
        model_step(1, LM_B);
    end

    logic [3:0]   d_gnt[2];
    logic         d_save[2];
    logic [W-1:0] d_in[2];
    logic         d_busy[2];
    logic         d_exp[2];
    assign d_gnt[0] = bus_a.gnt;
    assign d_gnt[1] = bus_b.gnt;
    assign d_save[0] = bus_a.mem_save;
    assign d_save[1] = bus_b.mem_save;
    assign d_in[0] = bus_a.mem_in;
    assign d_in[1] = bus_b.mem_in;
    assign d_busy[0] = bus_a.busy;
    assign d_busy[1] = bus_b.busy;
    assign d_exp[0] = bus_a.lock_expired;
    assign d_exp[1] = bus_b.lock_expired;

    // scoreboard compare, once per cycle on the falling edge
    always @(negedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (m_valid[n]) begin
                chk($sformatf("gnt%0d@%0d", n, edge_no), 32'(d_gnt[n]), 32'(e_gnt[n]));
                chk($sformatf("save%0d@%0d", n, edge_no), 32'(d_save[n]), 32'(e_save[n]));
                chk($sformatf("mem_in%0d@%0d", n, edge_no), 32'(d_in[n]), 32'(e_in[n]));
                chk($sformatf("busy%0d@%0d", n, edge_no), 32'(d_busy[n]), 32'(e_busy[n]));
                chk($sformatf("expired%0d@%0d", n, edge_no), 32'(d_exp[n]), 32'(e_exp[n]));
                chk($sformatf("save_or_gnt%0d@%0d", n, edge_no), 32'(d_save[n]), 32'(|d_gnt[n]));
            end
        end
    end

    // driver
    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                        input logic [4*W-1:0] wd);
        @(negedge clk);
        rst   = r;
        req   = rq;
        lock  = lk;
        wdata = wd;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4*W-1:0] wd(input logic [W-1:0] a0, input logic [W-1:0] a1,
                                          input logic [W-1:0] a2, input logic [W-1:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    logic [3:0] rr_seq[5];

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        lock = 4'b0000;
        wdata = '0;
        rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // reset edge with requests present: nothing granted
        step(1'b1, 4'b1111, 4'b0000, wd(5, 6, 7, 8));
        chk("rst_gnt", 32'(bus_a.gnt), 32'h0);
        chk("rst_mem_in", 32'(bus_a.mem_in), 32'h0);
        chk("rst_busy", 32'(bus_a.busy), 32'h0);

        // single request, then ptr moved to 1
        step(1'b0, 4'b0001, 4'b0000, wd(1, 0, 0, 0));
        chk("first_gnt", 32'(bus_a.gnt), 32'h1);
        chk("first_save", 32'(bus_a.mem_save), 32'h1);
        chk("first_mem_in", 32'(bus_a.mem_in), 32'h1);
        step(1'b0, 4'b0011, 4'b0000, wd(2, 3, 0, 0));
        chk("ptr1_gnt", 32'(bus_a.gnt), 32'h2);
        chk("ptr1_mem_in", 32'(bus_a.mem_in), 32'h3);
        step(1'b0, 4'b0000, 4'b0000, wd(9, 9, 9, 9));
        chk("idle_gnt", 32'(bus_a.gnt), 32'h0);
        chk("idle_mem_in_hold", 32'(bus_a.mem_in), 32'h3);

        // ptr=2, wrap-around scan
        step(1'b0, 4'b1001, 4'b0000, wd(4, 0, 0, 12));
        chk("wrap_gnt", 32'(bus_a.gnt), 32'h8);
        chk("wrap_mem_in", 32'(bus_a.mem_in), 32'hc);
        step(1'b0, 4'b0001, 4'b0000, wd(10, 0, 0, 0));
        chk("after_wrap_gnt", 32'(bus_a.gnt), 32'h1);

        // full rotation from ptr 0
        step(1'b1, 4'b0000, 4'b0000, '0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 4'b1111, 4'b0000, wd(W'(k), W'(k + 1), W'(k + 2), W'(k + 3)));
            chk($sformatf("rr_gnt%0d", k), 32'(bus_a.gnt), 32'(rr_seq[k]));
        end

        // held lock by requester 1 until forced release
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 4'b1111, 4'b0010, wd(1, W'(k + 2), 3, 4));
            chk($sformatf("lock_gnt%0d", k), 32'(bus_a.gnt), 32'h2);
            chk($sformatf("lock_busy%0d", k), 32'(bus_a.busy), 32'h1);
            if (k == 1) begin
                chk("b_expired", 32'(bus_b.lock_expired), 32'h1);
                chk("b_expired_gnt", 32'(bus_b.gnt), 32'h0);
            end
        end
        step(1'b0, 4'b1111, 4'b0010, wd(1, 2, 3, 4));
        chk("force_gnt", 32'(bus_a.gnt), 32'h0);
        chk("force_expired", 32'(bus_a.lock_expired), 32'h1);
        chk("force_busy", 32'(bus_a.busy), 32'h0);
        step(1'b0, 4'b1111, 4'b0010, wd(1, 2, 3, 4));
        chk("post_force_gnt", 32'(bus_a.gnt), 32'h4);
        chk("post_force_expired", 32'(bus_a.lock_expired), 32'h0);

        // voluntary release after 3 grants
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 4'b0010, 4'b0010, wd(0, W'(k + 5), 0, 0));
            chk($sformatf("vol_gnt%0d", k), 32'(bus_a.gnt), 32'h2);
        end
        step(1'b0, 4'b0110, 4'b0000, wd(0, 1, 2, 0));
        chk("vol_rel_gnt", 32'(bus_a.gnt), 32'h0);
        chk("vol_rel_busy", 32'(bus_a.busy), 32'h0);
        chk("vol_rel_expired", 32'(bus_a.lock_expired), 32'h0);
        step(1'b0, 4'b0110, 4'b0000, wd(0, 1, 2, 0));
        chk("vol_next_gnt", 32'(bus_a.gnt), 32'h4);

        // lock owner 2, owner idle while others request, then reset mid-lock
        step(1'b0, 4'b0100, 4'b0100, wd(0, 0, 7, 0));
        chk("own2_gnt", 32'(bus_a.gnt), 32'h4);
        step(1'b0, 4'b1011, 4'b0100, wd(1, 1, 1, 1));
        chk("own2_idle_gnt", 32'(bus_a.gnt), 32'h0);
        chk("own2_idle_busy", 32'(bus_a.busy), 32'h1);
        chk("own2_idle_mem_in", 32'(bus_a.mem_in), 32'h7);
        step(1'b1, 4'b1111, 4'b1111, wd(3, 3, 3, 3));
        chk("midlock_rst_gnt", 32'(bus_a.gnt), 32'h0);
        chk("midlock_rst_busy", 32'(bus_a.busy), 32'h0);
        chk("midlock_rst_mem_in", 32'(bus_a.mem_in), 32'h0);
        step(1'b0, 4'b1000, 4'b0000, wd(0, 0, 0, 9));
        chk("after_rst_gnt", 32'(bus_a.gnt), 32'h8);

        step(1'b0, 4'b0000, 4'b0000, '0);
        step(1'b0, 4'b0000, 4'b0000, '0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/bit_memory_arbiter.md
BIT_MEMORY_ARBITER -- requirements
Module: bit_memory_arbiter

Interface
REQ-001 Parameter UUID, default 0, opaque component identifier with no functional effect.
REQ-002 Parameter NAME, default "", opaque instance label with no functional effect.
REQ-003 Parameter WIDTH, default 1, width of each requester's write data and of mem_in.
REQ-004 Parameter LOCK_MAX, default 8, range >=1, maximum LOCKED tenure in cycles.
REQ-005 Reset is rst, synchronous, active-high; clock is clk.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 req  input  4  per-requester write request, bit i = requester i.
REQ-009 lock  input  4  per-requester lock request, sampled only for the requester being granted or owning the lock.
REQ-010 wdata  input  4*WIDTH  packed write data; requester i uses bits [i*WIDTH +: WIDTH].
REQ-011 gnt  output  4  registered one-hot grant; all zero when no write is issued.
REQ-012 mem_save  output  1  registered save strobe to the shared storage cell.
REQ-013 mem_in  output  WIDTH  registered write data to the shared storage cell.
REQ-014 busy  output  1  high while the FSM is in LOCKED.
REQ-015 lock_expired  output  1  one-cycle pulse on forced lock release.

Function
REQ-016 The block SHALL implement two states, IDLE and LOCKED, plus a 2-bit round-robin pointer ptr and a hold counter hold_cnt sized ceil(log2(LOCK_MAX+1)) bits.
REQ-017 All outputs SHALL be registered; a request sampled at edge t appears on gnt/mem_save/mem_in after edge t (one-cycle latency).
REQ-018 In IDLE with any req bit set, the block SHALL grant the first set req bit found scanning ptr, ptr+1, ... mod 4; gnt=onehot(i), mem_save=1, mem_in=wdata[i] sampled at the same edge.
REQ-019 In IDLE, after a grant to i with lock[i]=0, ptr SHALL become (i+1) mod 4 and the state SHALL remain IDLE.
REQ-020 In IDLE, after a grant to i with lock[i]=1, the state SHALL become LOCKED, owner=i, hold_cnt=1, and ptr SHALL be unchanged.
REQ-021 In IDLE with req=0, gnt SHALL be 0 and mem_save 0, and mem_in, ptr and the state SHALL hold.
REQ-022 In LOCKED, the release check SHALL have priority: if lock[owner]=0, the next state SHALL be IDLE, ptr=(owner+1) mod 4, and gnt=0, mem_save=0 (one bubble cycle, no arbitration on the release edge).
REQ-023 In LOCKED with lock[owner]=1 and hold_cnt==LOCK_MAX, a forced release SHALL occur: IDLE, ptr=(owner+1) mod 4, gnt=0, mem_save=0, lock_expired=1 for exactly one cycle.
REQ-024 Otherwise in LOCKED, with req[owner]=1, the block SHALL set gnt=onehot(owner), mem_save=1, mem_in=wdata[owner]; with req[owner]=0, gnt=0 and mem_save=0; in both cases hold_cnt SHALL increment.
REQ-025 In LOCKED, requests from non-owners SHALL be ignored and never granted.
REQ-026 Under a held lock, the owner SHALL receive at most LOCK_MAX grants per tenure; LOCK_MAX=1 SHALL force release on the edge after entry.
REQ-027 mem_save SHALL equal the OR of gnt in every cycle.
REQ-028 lock_expired SHALL be 0 in every cycle other than the single cycle following a forced release.
REQ-029 busy SHALL be 1 exactly while the state register is LOCKED.

Reset
REQ-030 rst SHALL have priority over all other inputs at any edge, including mid-LOCKED.
REQ-031 After a reset edge: state=IDLE, ptr=0, hold_cnt=0, gnt=0, mem_save=0, mem_in=0, busy=0, lock_expired=0.
REQ-032 The block SHALL issue no grant in the cycle following a reset edge, regardless of req.

Verification
REQ-033 Reset, then req=0001 with wdata0=1 for one edge -> next cycle gnt=0001, mem_save=1, mem_in=1; a later req=0011 grants 0010 first (ptr=1).
REQ-034 req=1111 held, lock=0 -> gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles, mem_save=1 throughout.
REQ-035 LOCK_MAX=8, req=1111, lock=0010 held, ptr=1 -> gnt=0010 for 8 cycles with busy=1, then one cycle gnt=0 with lock_expired=1, then gnt=0100.
REQ-036 Requester 1 locks, receives 3 grants, drops lock -> one cycle gnt=0, busy=0, then requester 2 granted if requesting; no lock_expired.
REQ-037 rst asserted while LOCKED owner=2 -> next cycle all outputs 0; then req=1000 -> gnt=1000 one cycle later.
REQ-038 ptr=2 with req=1001 -> gnt=1000; ptr becomes 0; the next edge with req=0001 grants 0001.
